// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch/loader arbiter.
// Holds the sequencer state encoding and the lane-insert helper used during assembly.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LAST = 2'd2,
    RESP = 2'd3
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP   = 32'h0000_0013;
  localparam int          IMEM_BEATS = 4;

  // Returns word with byte lane 'lane' replaced by 'b' (lane 0 = bits [7:0]).
  function automatic logic [31:0] imem_put_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w        = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter.sv
// Shares a single-port byte RAM between the IF stage (4-byte little-endian word fetch)
// and the boot loader (byte writes, strict priority while it is active).
module imem_fetch_arbiter
  import imem_pkg::*;
#(
  parameter  int IROM_SPACE = 1024,
  localparam int AW         = $clog2(IROM_SPACE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_addr,
  input  logic [7:0]    ld_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam logic [1:0] LAST_BEAT = 2'(IMEM_BEATS - 1);

  imem_state_e   r_state;
  imem_state_e   w_next;
  logic [AW-1:0] r_base;
  logic [1:0]    r_beat;
  logic [31:0]   r_data;
  logic          r_err;
  logic          r_rsp_valid;

  logic          w_idle;
  logic          w_ld_fire;
  logic          w_req_fire;
  logic          w_ld_in_range;
  logic          w_req_in_range;
  logic [AW-1:0] w_rd_addr;

  assign w_idle         = (r_state == IDLE) && !rst;
  assign w_ld_in_range  = (ld_addr[31:AW] == {(32-AW){1'b0}});
  assign w_req_in_range = (req_addr[31:AW] == {(32-AW){1'b0}});
  assign w_ld_fire      = w_idle && !flush && ld_valid;
  assign w_req_fire     = w_idle && !flush && !ld_valid && req_valid;
  assign w_rd_addr      = r_base + {{(AW-2){1'b0}}, r_beat};

  assign ld_ready  = w_idle && !flush;
  assign req_ready = w_idle && !flush && !ld_valid;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

  // Next-state and RAM port drive; loader bytes go straight through in IDLE.
  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 8'h00;
    if (rst) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ld_fire) begin
            mem_en    = 1'b1;
            mem_we    = w_ld_in_range;
            mem_addr  = ld_addr[AW-1:0];
            mem_wdata = ld_data;
          end else if (w_req_fire) begin
            w_next = w_req_in_range ? RD : RESP;
          end else begin
            w_next = IDLE;
          end
        end
        RD: begin
          mem_en   = 1'b1;
          mem_addr = w_rd_addr;
          if (r_beat == LAST_BEAT) begin
            w_next = LAST;
          end else begin
            w_next = RD;
          end
        end
        LAST: begin
          w_next = RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            w_next = IDLE;
          end else begin
            w_next = RESP;
          end
        end
        default: begin
          w_next = IDLE;
        end
      endcase
      if (flush) begin
        w_next = IDLE;
      end else begin
        w_next = w_next;
      end
    end
  end

  // State, fetch context and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= {AW{1'b0}};
      r_beat      <= 2'd0;
      r_data      <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= (w_next == RESP);
      case (r_state)
        IDLE: begin
          if (w_req_fire && w_req_in_range) begin
            r_base <= req_addr[AW-1:0];
            r_beat <= 2'd0;
            r_data <= 32'h0000_0000;
            r_err  <= 1'b0;
          end else if (w_req_fire) begin
            r_data <= IMEM_NOP;
            r_err  <= 1'b1;
          end
        end
        RD: begin
          r_beat <= r_beat + 2'd1;
          // Read data lags the address by one cycle, so beat N lands lane N-1.
          if (r_beat != 2'd0) begin
            r_data <= imem_put_lane(r_data, r_beat - 2'd1, mem_rdata);
          end
        end
        LAST: begin
          r_data <= imem_put_lane(r_data, LAST_BEAT, mem_rdata);
        end
        RESP: begin
          if (flush || rsp_ready) begin
            r_err <= 1'b0;
          end
        end
        default: begin
          r_beat <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomised self-checking bench for imem_fetch_arbiter against a byte-array reference model.
module tb_imem_fetch_arbiter;

  localparam int SPACE = 1024;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  ram [0:SPACE-1];
  logic [7:0]  ref_mem [0:SPACE-1];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;

  imem_fetch_arbiter #(.IROM_SPACE(SPACE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural synchronous byte RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int b;
    if (a >= 32'(SPACE)) return 32'h0000_0013;
    b = int'(a);
    return {ref_mem[(b+3)%SPACE], ref_mem[(b+2)%SPACE], ref_mem[(b+1)%SPACE], ref_mem[b]};
  endfunction

  // one loader byte in the current cycle; leaves ld_valid asserted
  task automatic ld_byte(input logic [31:0] a, input logic [7:0] d);
    logic in_rng;
    in_rng = (a < 32'(SPACE));
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    vectors++;
    if (ld_ready !== 1'b1 || req_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== in_rng ||
        mem_addr !== a[9:0] || mem_wdata !== d) begin
      errors++;
      $display("FAIL ld_byte a=%h: rdy=%b rq=%b en=%b we=%b ad=%h wd=%h, expected 1 0 1 %b %h %h",
               a, ld_ready, req_ready, mem_en, mem_we, mem_addr, mem_wdata, in_rng, a[9:0], d);
    end
    if (in_rng) ref_mem[a[9:0]] = d;
    @(negedge clk);
  endtask

  // full fetch: acceptance, read sequence, latency, data, backpressure hold, handshake
  task automatic run_fetch(input logic [31:0] a, input int hold);
    int k, w;
    logic in_rng;
    logic [31:0] ew;
    in_rng = (a < 32'(SPACE));
    ew = exp_word(a);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    w = 0;
    #1;
    while (!req_ready && w < 20) begin @(negedge clk); #1; w++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL fetch_accept a=%h: req_ready=%b expected 1", a, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    #1;
    while (!rsp_valid && k < 20) begin
      vectors++;
      if (k <= 4 && (mem_en !== 1'b1 || mem_we !== 1'b0 || int'(mem_addr) != (int'(a) + k - 1) % SPACE)) begin
        errors++;
        $display("FAIL read_beat%0d a=%h: en=%b we=%b ad=%h expected 1 0 %h", k, a, mem_en, mem_we,
                 mem_addr, (int'(a) + k - 1) % SPACE);
      end else if (k > 4 && mem_en !== 1'b0) begin
        errors++; $display("FAIL read_idle k=%0d: mem_en=%b expected 0", k, mem_en);
      end
      @(negedge clk); #1; k++;
    end
    vectors++;
    if (k != (in_rng ? 6 : 1)) begin
      errors++; $display("FAIL latency a=%h: got %0d expected %0d", a, k, in_rng ? 6 : 1);
    end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== ew || rsp_err !== !in_rng || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rsp a=%h: v=%b data=%h err=%b en=%b expected 1 %h %b 0", a, rsp_valid, rsp_data,
               rsp_err, mem_en, ew, !in_rng);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== ew || rsp_err !== !in_rng) begin
        errors++;
        $display("FAIL hold%0d a=%h: v=%b data=%h err=%b expected 1 %h %b", i, a, rsp_valid, rsp_data,
                 rsp_err, ew, !in_rng);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rsp_drop a=%h: v=%b err=%b expected 0 0", a, rsp_valid, rsp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; ld_valid = 1'b1; req_addr = 32'h0; ld_addr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b0 || ld_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 ||
        rsp_err !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_vals: rq=%b ld=%b v=%b d=%h e=%b en=%b we=%b ad=%h wd=%h expected all zero",
               req_ready, ld_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0; req_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < SPACE; i++) ld_byte(32'(i), 8'($urandom));
    ld_valid = 1'b0;
  endtask

  task automatic test_aligned();
    ld_byte(32'h10, 8'h13); ld_byte(32'h11, 8'h05); ld_byte(32'h12, 8'h10); ld_byte(32'h13, 8'h00);
    ld_valid = 1'b0;
    vectors++;
    if (exp_word(32'h10) !== 32'h0010_0513) begin
      errors++; $display("FAIL aligned_model: got %h expected 00100513", exp_word(32'h10));
    end
    run_fetch(32'h10, 0);
  endtask

  task automatic test_wrap();
    ld_byte(32'h3FE, 8'hAA); ld_byte(32'h3FF, 8'hBB); ld_byte(32'h000, 8'hCC); ld_byte(32'h001, 8'hDD);
    ld_valid = 1'b0;
    run_fetch(32'h3FE, 0);
    run_fetch(32'h3FD, 1);
    run_fetch(32'h3FF, 0);
  endtask

  task automatic test_out_of_range();
    run_fetch(32'h400, 0);
    run_fetch(32'hFFFF_FFFF, 2);
    ld_byte(32'h0000_0405, 8'h5A);
    ld_valid = 1'b0;
    run_fetch(32'h5, 0);
  endtask

  task automatic test_loader_priority();
    req_valid = 1'b1; req_addr = 32'h20;
    for (int i = 0; i < 3; i++) ld_byte(32'h20 + 32'(i), 8'($urandom));
    ld_valid = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL prio_cycle4: req_ready=%b expected 1", req_ready);
    end
    run_fetch(32'h20, 0);
  endtask

  task automatic test_flush();
    logic [31:0] a;
    a = 32'($urandom_range(0, SPACE - 1));
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);                   // handshake in T
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);   // now in T+2 .. advance to T+3
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (ld_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_T3: ld_ready=%b rsp_valid=%b expected 0 0", ld_ready, rsp_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_T4: req_ready=%b rsp_valid=%b mem_en=%b expected 1 0 0", req_ready, rsp_valid, mem_en);
    end
    run_fetch(32'($urandom_range(0, SPACE - 1)), 0);
    // flush in RESP beats a same-cycle handshake and drops the response
    req_valid = 1'b1; req_addr = 32'h800;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_resp: rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    int acc_t [2];
    int na, nr;
    addrs[0] = 32'($urandom_range(0, SPACE - 1));
    addrs[1] = 32'($urandom_range(0, SPACE - 1));
    na = 0; nr = 0;
    req_valid = 1'b1; req_addr = addrs[0]; rsp_ready = 1'b1;
    for (int i = 0; i < 30 && nr < 2; i++) begin
      #1;
      if (rsp_valid && nr < 2) begin
        vectors++;
        if (rsp_data !== exp_word(addrs[nr]) || rsp_err !== 1'b0) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", nr, rsp_data, exp_word(addrs[nr]));
        end
        nr++;
      end
      if (req_valid && req_ready) begin
        acc_t[na] = cyc;
        na++;
      end
      @(negedge clk);
      if (na == 1) req_addr = addrs[1];
      if (na == 2) req_valid = 1'b0;
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    vectors++;
    if (na != 2 || nr != 2 || acc_t[1] - acc_t[0] != 7) begin
      errors++;
      $display("FAIL b2b_rate: accepts=%0d rsps=%0d spacing=%0d expected 2 2 7", na, nr, acc_t[1] - acc_t[0]);
    end
  endtask

  task automatic test_backpressure();
    run_fetch(32'($urandom_range(0, SPACE - 1)), 5);
    run_fetch(32'h0000_1000, 5);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || ld_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_comb: rq=%b ld=%b en=%b expected 0 0 0", req_ready, ld_ready, mem_en);
    end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 10'h0) begin
      errors++;
      $display("FAIL rst_mid_regs: v=%b d=%h e=%b en=%b ad=%h expected 0 0 0 0 0", rsp_valid, rsp_data, rsp_err,
               mem_en, mem_addr);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL rst_mid_lost%0d: v=%b en=%b expected 0 0", i, rsp_valid, mem_en);
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] a;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) begin
          a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(SPACE, 4 * SPACE)) : 32'($urandom_range(0, 63));
          ld_byte(a, 8'($urandom));
        end
        ld_valid = 1'b0;
      end else begin
        a = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h0000_0400) : 32'($urandom_range(0, 63));
        run_fetch(a, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 8'h0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_aligned();
    test_wrap();
    test_out_of_range();
    test_loader_priority();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
